// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its stage registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;
    localparam int          REG_AW    = 5;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard flag: the load in EX writes a register that the ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    output logic              lu_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign lu_o = ex_memread_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline with a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_branch_taken_i,
    input  logic              ex_mul_start_i,
    input  logic              mem_stall_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_stall_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_stall_o,
    output logic              ex_mem_flush_o,
    output logic              mem_wb_stall_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int            CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [CW-1:0]      mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic lu;
    logic mul_frz;
    logic pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, memwb_st;

    hazard_detect u_hazard_detect (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .lu_o         (lu)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        ret_d     = ret_q;
        mul_cnt_d = mul_cnt_q;
        mul_frz   = 1'b0;
        pc_st     = 1'b0;
        ifid_st   = 1'b0;
        ifid_fl   = 1'b0;
        idex_st   = 1'b0;
        idex_fl   = 1'b0;
        exmem_st  = 1'b0;
        exmem_fl  = 1'b0;
        memwb_st  = 1'b0;

        if (mem_stall_i) begin
            {pc_st, ifid_st, idex_st, exmem_st, memwb_st} = '1;
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) ret_d = state_q;
        end else begin
            case (state_q)
                MEM_WAIT: begin
                    // The release cycle counts as one multi-cycle EX step when one was interrupted.
                    if (ret_q == MUL_BUSY) begin
                        mul_frz   = 1'b1;
                        mul_cnt_d = mul_cnt_q - 1'b1;
                        state_d   = (mul_cnt_q == CW'(1)) ? RUN : MUL_BUSY;
                    end else begin
                        state_d = RUN;
                        ifid_fl = id_branch_taken_i;
                    end
                end
                MUL_BUSY: begin
                    mul_frz   = 1'b1;
                    mul_cnt_d = mul_cnt_q - 1'b1;
                    if (mul_cnt_q == CW'(1)) state_d = RUN;
                end
                default: begin
                    if (ex_mul_start_i) begin
                        mul_frz   = 1'b1;
                        mul_cnt_d = MUL_LOAD;
                        state_d   = (MUL_LAT == 2) ? RUN : MUL_BUSY;
                    end else if (lu) begin
                        pc_st   = 1'b1;
                        ifid_st = 1'b1;
                        idex_fl = 1'b1;
                    end else begin
                        ifid_fl = id_branch_taken_i;
                    end
                end
            endcase
        end

        if (mul_frz) begin
            pc_st    = 1'b1;
            ifid_st  = 1'b1;
            idex_st  = 1'b1;
            exmem_fl = 1'b1;
        end

        // A held IF/ID cannot also take a NOP; ID re-resolves the branch next cycle.
        if (ifid_st) ifid_fl = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            mul_cnt_q <= mul_cnt_d;
            if (pc_st && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the inputs.
    assign pc_stall_o     = rst_i & pc_st;
    assign if_id_stall_o  = rst_i & ifid_st;
    assign if_id_flush_o  = rst_i & ifid_fl;
    assign id_ex_stall_o  = rst_i & idex_st;
    assign id_ex_flush_o  = rst_i & idex_fl;
    assign ex_mem_stall_o = rst_i & exmem_st;
    assign ex_mem_flush_o = rst_i & exmem_fl;
    assign mem_wb_stall_o = rst_i & memwb_st;
    assign busy_o         = rst_i & (state_q != RUN);
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: driver queues expectations, monitor compares.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  id_rs_i = '0;
    logic [4:0]  id_rt_i = '0;
    logic        id_uses_rt_i = 1'b0;
    logic        ex_memread_i = 1'b0;
    logic [4:0]  ex_rt_i = '0;
    logic        id_branch_taken_i = 1'b0;
    logic        ex_mul_start_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o;
    logic        ex_mem_stall_o, ex_mem_flush_o, mem_wb_stall_o, busy_o;
    logic [31:0] stall_cnt_o;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs_i           (id_rs_i),
        .id_rt_i           (id_rt_i),
        .id_uses_rt_i      (id_uses_rt_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rt_i           (ex_rt_i),
        .id_branch_taken_i (id_branch_taken_i),
        .ex_mul_start_i    (ex_mul_start_i),
        .mem_stall_i       (mem_stall_i),
        .pc_stall_o        (pc_stall_o),
        .if_id_stall_o     (if_id_stall_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_stall_o     (id_ex_stall_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .ex_mem_stall_o    (ex_mem_stall_o),
        .ex_mem_flush_o    (ex_mem_flush_o),
        .mem_wb_stall_o    (mem_wb_stall_o),
        .busy_o            (busy_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [8:0]  flags;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Flag order: pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl, memwb_st, busy
    localparam logic [8:0] F_NONE = 9'b000000000;
    localparam logic [8:0] F_LU   = 9'b110010000;
    localparam logic [8:0] F_BR   = 9'b001000000;
    localparam logic [8:0] F_MUL0 = 9'b110100100;
    localparam logic [8:0] F_MUL1 = 9'b110100101;
    localparam logic [8:0] F_MEM0 = 9'b110101010;
    localparam logic [8:0] F_MEM1 = 9'b110101011;
    localparam logic [8:0] F_BUSY = 9'b000000001;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got flags=%b cnt=%0d, expected flags=%b cnt=%0d",
                      name, act[40:32], act[31:0], req[40:32], req[31:0]);
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name,
                  {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
                   ex_mem_stall_o, ex_mem_flush_o, mem_wb_stall_o, busy_o, stall_cnt_o},
                  {e.flags, e.cnt});
        end
    end

    task automatic drive(input string name, input logic rst,
                         input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic memread, input logic [4:0] ex_rt,
                         input logic br, input logic mul, input logic mem,
                         input logic [8:0] ef, input logic [31:0] ec);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i             = rst;
        id_rs_i           = rs;
        id_rt_i           = rt;
        id_uses_rt_i      = uses_rt;
        ex_memread_i      = memread;
        ex_rt_i           = ex_rt;
        id_branch_taken_i = br;
        ex_mul_start_i    = mul;
        mem_stall_i       = mem;
        e.name  = name;
        e.flags = ef;
        e.cnt   = ec;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [8:0] ef, input logic [31:0] ec);
        drive(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ef, ec);
    endtask

    initial begin
        int budget;
        //     name              rst  rs     rt     urt   mrd   exrt   br    mul   mem   flags   cnt
        drive("reset_quiet",     0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, F_NONE, 0);
        idle ("after_reset",        F_NONE, 0);
        drive("lu_rs",           1, 5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, F_LU,   0);
        idle ("lu_one_cycle",       F_NONE, 1);
        drive("lu_r0_ignored",   1, 5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, F_NONE, 1);
        drive("lu_rt",           1, 5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, F_LU,   1);
        drive("rt_not_used",     1, 5'd3,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, F_NONE, 2);
        drive("branch",          1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, F_BR,   2);
        drive("branch_plus_lu",  1, 5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, F_LU,   2);
        drive("branch_retry",    1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, F_BR,   3);
        drive("mul_c1",          1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, F_MUL0, 3);
        idle ("mul_c2",             F_MUL1, 4);
        idle ("mul_c3",             F_MUL1, 5);
        idle ("mul_done",           F_NONE, 6);
        drive("mulm_c1",         1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, F_MUL0, 6);
        drive("mulm_mem1",       1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, F_MEM1, 7);
        drive("mulm_mem2",       1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, F_MEM1, 8);
        idle ("mulm_resume",        F_MUL1, 9);
        idle ("mulm_last",          F_MUL1, 10);
        idle ("mulm_done",          F_NONE, 11);
        drive("mulr_c1",         1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, F_MUL0, 11);
        idle ("mulr_c2",            F_MUL1, 12);
        drive("rst_mid_mul",     0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, F_NONE, 0);
        idle ("rst_release",        F_NONE, 0);
        idle ("stays_run",          F_NONE, 0);
        drive("mem_from_run",    1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, F_MEM0, 0);
        idle ("mem_release",        F_BUSY, 1);
        idle ("back_to_run",        F_NONE, 1);

        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk_i);
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
- Detects load-use hazards and taken branches/jumps.
- Freezes the pipe for multi-cycle EX operations and data-memory wait states.
- Drives each stage register's stall_i/flush_i inputs.
- Keeps a stall-cycle performance counter.

Parameters:
MUL_LAT, 4, total EX cycles of a multi-cycle op (>=2); stall length is MUL_LAT-1.
CNT_W, 32, width of the stall performance counter.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-low
id_rs_i  input  5  rs field of instruction in ID
id_rt_i  input  5  rt field of instruction in ID
id_uses_rt_i  input  1  ID instruction reads rt as a source
ex_memread_i  input  1  EX instruction is a load
ex_rt_i  input  5  destination rt of EX load
id_branch_taken_i  input  1  branch/jump resolved taken in ID
ex_mul_start_i  input  1  first EX cycle of a multi-cycle op
mem_stall_i  input  1  data memory not ready this cycle
pc_stall_o  output  1  hold PC
if_id_stall_o  output  1  hold IF/ID
if_id_flush_o  output  1  load NOP into IF/ID
id_ex_stall_o  output  1  hold ID/EX
id_ex_flush_o  output  1  insert bubble into ID/EX
ex_mem_stall_o  output  1  hold EX/MEM
ex_mem_flush_o  output  1  insert bubble into EX/MEM
mem_wb_stall_o  output  1  hold MEM/WB
busy_o  output  1  state != RUN
stall_cnt_o  output  CNT_W  cycles in which pc_stall_o=1, saturating

Behaviour:
- States: RUN, MUL_BUSY, MEM_WAIT. Registers:
  - state
  - ret_state (RUN or MUL_BUSY)
  - mul_cnt (width clog2(MUL_LAT))
  - stall_cnt
- Reset values (async, rst_i=0): state=RUN, ret_state=RUN, mul_cnt=0, stall_cnt=0.
- All outputs are combinational from state and current inputs. During reset every stall/flush output is 0, busy_o=0 and stall_cnt_o=0.
- Load-use hazard LU = ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Priority per cycle, highest first:
  1. mem_stall_i=1 (any state): pc, if_id, id_ex, ex_mem and mem_wb stalls all 1; all flushes 0.
     - Next state is MEM_WAIT.
     - If arriving from RUN or MUL_BUSY, ret_state is set to the current state. If already in MEM_WAIT, ret_state is kept.
     - mul_cnt is frozen.
  2. state=MEM_WAIT with mem_stall_i=0: outputs as in RUN-without-hazard, except that when ret_state=MUL_BUSY the MUL_BUSY outputs apply. Next state is ret_state.
  3. state=MUL_BUSY: pc, if_id and id_ex stall=1; ex_mem_flush_o=1; other outputs 0.
     - mul_cnt decrements each cycle.
     - When mul_cnt==1, next state is RUN.
  4. state=RUN with ex_mul_start_i=1: outputs as in MUL_BUSY. mul_cnt loads MUL_LAT-2; next state is MUL_BUSY, or RUN if MUL_LAT==2. The freeze therefore totals MUL_LAT-1 cycles.
  5. state=RUN with LU=1: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly one cycle. No state change; the hazard clears because the load advances.
  6. state=RUN with id_branch_taken_i=1: if_id_flush_o=1 only.
  7. Otherwise all outputs are 0.
- Stall beats flush on the same stage: whenever if_id_stall_o=1, if_id_flush_o is forced to 0. A taken branch coincident with LU, MUL or MEM is therefore dropped. ID re-resolves the branch on the next cycle.
- A rt/rs value of 0 never creates a hazard.
- stall_cnt increments on every cycle with pc_stall_o=1 and holds at all-ones.
- ex_mul_start_i during MUL_BUSY or MEM_WAIT is ignored; the ISA cannot issue one.
- Reset asserted mid-MUL_BUSY or mid-MEM_WAIT returns immediately to RUN with all outputs 0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, MUL_BUSY=2'd1, MEM_WAIT=2'd2)
  - NOP encoding constant 32'h0000_0020 used by all flushable stage registers
  - register-index width constant REG_AW=5
- One natural sub-module: hazard_detect. It is purely combinational and produces the LU flag from the register fields. Everything else stays in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> one cycle of pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1; stall_cnt_o=1. With ex_rt_i=0 -> no stall.
- Branch: id_branch_taken_i=1, no hazard -> if_id_flush_o=1, all stalls 0, stall_cnt_o unchanged.
- Branch plus LU same cycle -> if_id_stall_o=1, if_id_flush_o=0. Next cycle, branch alone -> if_id_flush_o=1.
- MUL, MUL_LAT=4: ex_mul_start_i pulse -> pc_stall_o high exactly 3 cycles, ex_mem_flush_o high those 3 cycles, busy_o high cycles 2-3, then RUN; stall_cnt_o=3.
- mem_stall_i high 2 cycles during the 2nd MUL cycle -> all five stalls high, no flushes for 2 cycles. MUL then resumes with its remaining count; total pc_stall_o cycles = 5.
- rst_i low in the middle of MUL_BUSY -> outputs 0 asynchronously, stall_cnt_o=0. After release with no inputs asserted, state stays RUN.
